lfsr_checker: RTL and testbench

//  Receive-side PRBS checker for the 16-bit LFSR byte generator. Self-synchronises to an

---
 rtl/lfsr_checker.sv | 206 ++++++++++++++++++++
 tb/tb_lfsr_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker for the 16-bit LFSR byte generator.
//
// The checker synchronises itself to an incoming stream of 8-bit pseudo-random words. It
// predicts each next word, and it flags and counts mismatched words while it is locked.
// The generator polynomial is x^16 + x^14 + x^13 + x^11 + 1. The generator advances
// 8 steps per word, so two consecutive words {w[k-1], w[k]} are the full generator state.
//
// Optional feature (macro LFSR_CHK_BITERR_EN):
//   When the macro is defined, the bit_err_cnt output is present. It accumulates
//   popcount(in_rand ^ predicted) for every mismatched word while locked.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   block_enable  in   in_rand is valid this cycle; no state changes when 0
//   in_rand       in   received 8-bit word
//   clr_cnt       in   synchronous clear of the error counters (wins over a new error)
//   locked        out  checker is in the LOCKED state
//   err_pulse     out  one-cycle pulse per mismatched word while locked
//   err_cnt       out  saturating count of mismatched words while locked
//   bit_err_cnt   out  saturating count of mismatched bits (LFSR_CHK_BITERR_EN only)
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             block_enable,
  input  logic [7:0]       in_rand,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [ERR_W-1:0] bit_err_cnt
`endif
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LossW  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  // Advance the generator LFSR by one word (8 single-bit steps).
  function automatic logic [15:0] adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       sreg_q, sreg_d;       // predictor: {previous word, current word}
  logic [7:0]        prev_q, prev_d;       // HUNT history word
  logic              have_prev_q, have_prev_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [LossW-1:0]  loss_q, loss_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [15:0] pred;
  logic        mismatch;
  logic        count_err;

  assign pred     = adv8(sreg_q);
  assign mismatch = (in_rand != pred[7:0]);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    loss_d      = loss_q;
    err_pulse_d = 1'b0;
    count_err   = 1'b0;

    if (block_enable) begin
      unique case (state_q)
        StHunt: begin
          if (!have_prev_q) begin
            prev_d      = in_rand;
            have_prev_d = 1'b1;
          end else if ({prev_q, in_rand} == 16'h0000) begin
            // All-zero seed is the LFSR lock-up state; keep sliding the window.
            prev_d = in_rand;
          end else begin
            sreg_d  = {prev_q, in_rand};
            match_d = '0;
            state_d = StVerify;
          end
        end

        StVerify: begin
          if (!mismatch) begin
            sreg_d = pred;
            if (match_q == MatchW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            if ({sreg_q[7:0], in_rand} == 16'h0000) begin
              // Never reseed into lock-up; fall back to hunting with this word held.
              state_d     = StHunt;
              prev_d      = in_rand;
              have_prev_d = 1'b1;
            end else begin
              sreg_d = {sreg_q[7:0], in_rand};
            end
          end
        end

        StLocked: begin
          // Flywheel: advance from the predictor's own state whatever was received.
          sreg_d = pred;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
            if (loss_q == LossW'(LOSS_CNT - 1)) begin
              state_d     = StHunt;
              have_prev_d = 1'b0;
              loss_d      = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
        end

        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (count_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StHunt;
      sreg_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      loss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

`ifdef LFSR_CHK_BITERR_EN
  logic [ERR_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       bit_pop;
  logic [ERR_W:0]   bit_sum;

  always_comb begin
    bit_pop   = 4'($countones(in_rand ^ pred[7:0]));
    bit_sum   = {1'b0, bit_cnt_q} + (ERR_W + 1)'(bit_pop);
    bit_cnt_d = bit_cnt_q;
    if (clr_cnt) begin
      bit_cnt_d = '0;
    end else if (count_err) begin
      bit_cnt_d = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_err_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker. The driver issues one word per cycle and pushes the expected
// registered outputs for that cycle into a queue. A separate monitor pops one entry per cycle
// on the following falling edge and compares it with the DUT outputs. ERR_W is reduced to 6,
// which keeps the saturation test short.
module tb_lfsr_checker;

  localparam int unsigned ErrW   = 6;
  localparam int          ErrMax = (1 << ErrW) - 1;

  logic            clk;
  logic            rst;
  logic            block_enable;
  logic [7:0]      in_rand;
  logic            clr_cnt;
  logic            locked;
  logic            err_pulse;
  logic [ErrW-1:0] err_cnt;
`ifdef LFSR_CHK_BITERR_EN
  logic [ErrW-1:0] bit_err_cnt;
`endif

  lfsr_checker #(
    .LOCK_CNT(4),
    .LOSS_CNT(3),
    .ERR_W   (ErrW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .block_enable(block_enable),
    .in_rand     (in_rand),
    .clr_cnt     (clr_cnt),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt)
`ifdef LFSR_CHK_BITERR_EN
    ,
    .bit_err_cnt (bit_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    id;
    logic  lk;
    logic  pl;
    int    cnt;
    int    bits;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_sent = 0;
  logic [15:0] g;

  function automatic void chk(input string name, input int id, input logic [31:0] act,
                              input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s #%0d: got %0h, expected %0h", name, id, act, want);
    end
  endfunction

  // Generator model: advance 8 LFSR steps, emit the low byte.
  function automatic logic [15:0] adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    return r;
  endfunction

  function automatic logic [7:0] gen_word();
    g = adv8(g);
    return g[7:0];
  endfunction

  function automatic int sat(input int v);
    return (v > ErrMax) ? ErrMax : v;
  endfunction

  task automatic send(input logic en, input logic [7:0] w, input logic clr, input string name,
                      input logic lk, input logic pl, input int cnt, input int bits);
    exp_t e;
    @(negedge clk);
    #1;
    block_enable = en;
    in_rand      = w;
    clr_cnt      = clr;
    e.name = name; e.id = n_sent; e.lk = lk; e.pl = pl; e.cnt = cnt; e.bits = bits;
    exp_q.push_back(e);
    n_sent++;
  endtask

  // Let the monitor retire the last entry, then stop driving.
  task automatic drain();
    @(negedge clk);
    #1;
    block_enable = 1'b0;
    clr_cnt      = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_locked"}, 0, 32'(locked), 0);
    chk({name, "_pulse"}, 0, 32'(err_pulse), 0);
    chk({name, "_cnt"}, 0, 32'(err_cnt), 0);
`ifdef LFSR_CHK_BITERR_EN
    chk({name, "_bits"}, 0, 32'(bit_err_cnt), 0);
`endif
  endtask

  task automatic do_reset(input string name);
    drain();
    rst = 1'b0;
    #1;
    check_zero(name);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: one expectation per driven cycle, compared after the sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, "_locked"}, e.id, 32'(locked), 32'(e.lk));
        chk({e.name, "_pulse"}, e.id, 32'(err_pulse), 32'(e.pl));
        chk({e.name, "_cnt"}, e.id, 32'(err_cnt), 32'(e.cnt));
`ifdef LFSR_CHK_BITERR_EN
        chk({e.name, "_bits"}, e.id, 32'(bit_err_cnt), 32'(e.bits));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w;
    logic [15:0] h;
    logic        ok;
    int          bits;
    int          nerr;

    rst          = 1'b0;
    block_enable = 1'b0;
    in_rand      = 8'h00;
    clr_cnt      = 1'b0;
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    // 1: clean stream from seed ACE1; locked from the 6th word, no errors for 1000 words.
    g = 16'hACE1;
    for (int i = 1; i <= 1000; i++) send(1'b1, gen_word(), 1'b0, "clean", i >= 6, 1'b0, 0, 0);

    // 2: one word with bit 0 flipped, then an idle cycle and clean words.
    send(1'b1, gen_word() ^ 8'h01, 1'b0, "flip", 1'b1, 1'b1, 1, 1);
    send(1'b0, 8'h5A, 1'b0, "flip_idle", 1'b1, 1'b0, 1, 1);
    for (int i = 0; i < 5; i++) send(1'b1, gen_word(), 1'b0, "flip_after", 1'b1, 1'b0, 1, 1);

    // 3: clear counters, align so the next three generator words are non-zero, then
    // replace three words with 00: lock drops after the third, relocks within 6 words.
    send(1'b1, gen_word(), 1'b1, "clr", 1'b1, 1'b0, 0, 0);
    for (int t = 0; t < 100; t++) begin
      h  = g;
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
        h = adv8(h);
        if (h[7:0] == 8'h00) ok = 1'b0;
      end
      if (ok) break;
      send(1'b1, gen_word(), 1'b0, "align", 1'b1, 1'b0, 0, 0);
    end
    bits = 0;
    for (int k = 1; k <= 3; k++) begin
      w    = gen_word();
      bits = bits + $countones(w);
      send(1'b1, 8'h00, 1'b0, "zero3", k < 3, 1'b1, k, bits);
    end
    for (int j = 1; j <= 8; j++) send(1'b1, gen_word(), 1'b0, "relock", j >= 6, 1'b0, 3, bits);

    // 4: all-zero stream never leaves HUNT.
    do_reset("reset4");
    for (int i = 0; i < 20; i++) send(1'b1, 8'h00, 1'b0, "zeros", 1'b0, 1'b0, 0, 0);

    // 5: block_enable toggling on a clean stream; idle words carry junk that is ignored.
    do_reset("reset5");
    g = 16'hACE1;
    for (int i = 1; i <= 10; i++) begin
      send(1'b1, gen_word(), 1'b0, "tog_valid", i >= 6, 1'b0, 0, 0);
      send(1'b0, 8'hA5, 1'b0, "tog_idle", i >= 6, 1'b0, 0, 0);
    end

    // 6: saturation with alternating error/clean words, clear against an error, async reset.
    nerr = 0;
    for (int i = 0; i < ErrMax + 7; i++) begin
      nerr++;
      send(1'b1, gen_word() ^ 8'h01, 1'b0, "sat_err", 1'b1, 1'b1, sat(nerr), sat(nerr));
      send(1'b1, gen_word(), 1'b0, "sat_ok", 1'b1, 1'b0, sat(nerr), sat(nerr));
    end
    send(1'b1, gen_word() ^ 8'h01, 1'b1, "clr_win", 1'b1, 1'b1, 0, 0);
    send(1'b1, gen_word() ^ 8'h01, 1'b0, "post_clr", 1'b1, 1'b1, 1, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    block_enable = 1'b0;
    clr_cnt      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    @(negedge clk);
    #1;
    chk("queue_drained", 0, 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
